// File: rtl/tile_cfg_seq.sv
// rtl/tile_cfg_seq.sv - per-tile config memory and issue sequencer; TILE_CFG_SEQ_VALID_CHECK_EN refuses starts until every entry is written
module tile_cfg_seq #(
  parameter int KernelSize = 4,
  parameter int CfgWidth   = 49,
  parameter int AddrWidth  = $clog2(KernelSize)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] cfg_addr_i,
  input  logic [CfgWidth-1:0]  cfg_data_i,
  input  logic                 cfg_wr_en_i,
  input  logic                 cfg_wr_valid_i,
  output logic                 cfg_ready_o,
  input  logic                 run_start_i,
  input  logic [15:0]          run_iters_i,
  output logic [CfgWidth-1:0]  cfg_o,
  output logic                 cfg_valid_o,
  input  logic                 tile_stall_i,
  output logic [AddrWidth-1:0] cfg_idx_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CfgWidth-1:0]  mem_q [KernelSize];
  logic [CfgWidth-1:0]  mem_d [KernelSize];
  logic [CfgWidth-1:0]  cfg_q, cfg_d;
  logic                 cfg_valid_q, cfg_valid_d;
  logic [AddrWidth-1:0] idx_q, idx_d;
  logic [15:0]          iter_q, iter_d;
  logic [15:0]          iters_q, iters_d;
  logic                 wr_fire;
  logic                 start_ok;
  logic                 last_entry;
`ifdef TILE_CFG_SEQ_VALID_CHECK_EN
  logic [KernelSize-1:0] mask_q, mask_d;
  logic                  err_q, err_d;
`endif

  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == RUN) || (state_q == DONE);
  assign done_o      = (state_q == DONE);
  assign cfg_o       = cfg_q;
  assign cfg_valid_o = cfg_valid_q;
  assign cfg_idx_o   = idx_q;
`ifdef TILE_CFG_SEQ_VALID_CHECK_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

  assign wr_fire    = cfg_wr_valid_i && cfg_wr_en_i && cfg_ready_o && (int'(cfg_addr_i) < KernelSize);
  assign last_entry = (idx_q == AddrWidth'(KernelSize - 1));

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    cfg_d       = cfg_q;
    cfg_valid_d = cfg_valid_q;
    idx_d       = idx_q;
    iter_d      = iter_q;
    iters_d     = iters_q;
    start_ok    = 1'b0;
`ifdef TILE_CFG_SEQ_VALID_CHECK_EN
    mask_d      = mask_q;
    err_d       = 1'b0;
`endif

    if (wr_fire) begin
      mem_d[cfg_addr_i] = cfg_data_i;
`ifdef TILE_CFG_SEQ_VALID_CHECK_EN
      mask_d[cfg_addr_i] = 1'b1;
`endif
    end

    case (state_q)
      IDLE: begin
        if (run_start_i && (run_iters_i != 16'd0)) begin
`ifdef TILE_CFG_SEQ_VALID_CHECK_EN
          // A same-cycle write counts toward completing the mask.
          start_ok = &mask_d;
          err_d    = ~start_ok;
`else
          start_ok = 1'b1;
`endif
        end
        if (start_ok) begin
          // Write-first: a same-cycle write to entry 0 is issued immediately.
          cfg_d       = mem_d[0];
          cfg_valid_d = 1'b1;
          idx_d       = '0;
          iter_d      = 16'd0;
          iters_d     = run_iters_i;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (cfg_valid_q && !tile_stall_i) begin
          if (last_entry && (iter_q == iters_q - 16'd1)) begin
            cfg_d       = '0;
            cfg_valid_d = 1'b0;
            idx_d       = '0;
            state_d     = DONE;
          end else if (last_entry) begin
            idx_d  = '0;
            iter_d = iter_q + 16'd1;
            cfg_d  = mem_q[0];
          end else begin
            idx_d = idx_q + 1'b1;
            cfg_d = mem_q[idx_q + 1'b1];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      cfg_valid_q <= 1'b0;
      idx_q       <= '0;
      iter_q      <= 16'd0;
      iters_q     <= 16'd0;
      for (int i = 0; i < KernelSize; i++) mem_q[i] <= '0;
`ifdef TILE_CFG_SEQ_VALID_CHECK_EN
      mask_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      cfg_valid_q <= cfg_valid_d;
      idx_q       <= idx_d;
      iter_q      <= iter_d;
      iters_q     <= iters_d;
      for (int i = 0; i < KernelSize; i++) mem_q[i] <= mem_d[i];
`ifdef TILE_CFG_SEQ_VALID_CHECK_EN
      mask_q      <= mask_d;
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_tile_cfg_seq.sv
// tb/tb_tile_cfg_seq.sv - scoreboarded, table-driven bench for tile_cfg_seq
module tb_tile_cfg_seq;
  localparam int K  = 4;
  localparam int W  = 49;
  localparam int AW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [AW-1:0] cfg_addr_i;
  logic [W-1:0]  cfg_data_i;
  logic          cfg_wr_en_i, cfg_wr_valid_i, cfg_ready_o;
  logic          run_start_i;
  logic [15:0]   run_iters_i;
  logic [W-1:0]  cfg_o;
  logic          cfg_valid_o, tile_stall_i;
  logic [AW-1:0] cfg_idx_o;
  logic          busy_o, done_o, err_o;

  always #5 clk_i = ~clk_i;

  tile_cfg_seq #(.KernelSize(K), .CfgWidth(W), .AddrWidth(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_wr_en_i(cfg_wr_en_i), .cfg_wr_valid_i(cfg_wr_valid_i), .cfg_ready_o(cfg_ready_o),
    .run_start_i(run_start_i), .run_iters_i(run_iters_i), .cfg_o(cfg_o),
    .cfg_valid_o(cfg_valid_o), .tile_stall_i(tile_stall_i), .cfg_idx_o(cfg_idx_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct {
    logic [3:0][W-1:0] d;
    int                iters;
    int                stall_idx;
    int                stall_len;
    int                exp_valid;
  } vec_t;

  vec_t         vecs[4];
  logic [W-1:0] model[K];
  logic [W-1:0] exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           vc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_entry(input int addr, input logic [W-1:0] data);
    cfg_addr_i     = AW'(addr);
    cfg_data_i     = data;
    cfg_wr_en_i    = 1'b1;
    cfg_wr_valid_i = 1'b1;
    model[addr]    = data;
    tick();
    cfg_wr_en_i    = 1'b0;
    cfg_wr_valid_i = 1'b0;
  endtask

  task automatic run(input int iters, input int stall_idx, input int stall_len,
                     input bit wr0, input logic [W-1:0] wr0_data, input bit wr_in_run,
                     output int valid_cnt);
    int           last_valid, first_valid, done_cyc, done_cnt, stall_left;
    bit           prev_stall, broke;
    logic [W-1:0] prev_cfg, got;
    if (wr0) begin
      model[0]       = wr0_data;
      cfg_addr_i     = '0;
      cfg_data_i     = wr0_data;
      cfg_wr_en_i    = 1'b1;
      cfg_wr_valid_i = 1'b1;
    end
    for (int it = 0; it < iters; it++)
      for (int i = 0; i < K; i++) exp_q.push_back(model[i]);
    run_start_i = 1'b1;
    run_iters_i = 16'(iters);
    tick();
    run_start_i    = 1'b0;
    cfg_wr_en_i    = 1'b0;
    cfg_wr_valid_i = 1'b0;
    stall_left = stall_len;
    last_valid = -1; first_valid = -1; done_cyc = -1; done_cnt = 0;
    valid_cnt = 0; prev_stall = 0; prev_cfg = '0; broke = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tile_stall_i = cfg_valid_o && (stall_left > 0) && (int'(cfg_idx_o) == stall_idx);
      if (tile_stall_i) stall_left--;
      if (wr_in_run && cyc == 1) begin
        cfg_addr_i = AW'(1); cfg_data_i = W'(64'h99);
        cfg_wr_en_i = 1'b1; cfg_wr_valid_i = 1'b1;
      end else begin
        cfg_wr_en_i = 1'b0; cfg_wr_valid_i = 1'b0;
      end
      @(negedge clk_i);
      if (wr_in_run && cyc == 1) chk("ready_in_run", cfg_ready_o, 0);
      if (prev_stall) chk("stall_hold", cfg_o, prev_cfg);
      if (cfg_valid_o) begin
        valid_cnt++;
        last_valid = cyc;
        if (first_valid < 0) first_valid = cyc;
        if (!tile_stall_i) begin
          if (exp_q.size() == 0) got = '1;
          else got = exp_q.pop_front();
          chk("issued_cfg", cfg_o, got);
        end
      end else begin
        chk("cfg_zero_when_invalid", cfg_o, 0);
      end
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_stall = tile_stall_i && cfg_valid_o;
      prev_cfg   = cfg_o;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("done_pulse_len", done_cnt, 1);
        chk("idle_after_done", cfg_ready_o, 1);
        chk("busy_after_done", busy_o, 0);
        broke = 1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    tile_stall_i   = 1'b0;
    cfg_wr_en_i    = 1'b0;
    cfg_wr_valid_i = 1'b0;
    if (broke) tick();
    chk("done_seen", done_cyc >= 0, 1);
    chk("first_valid_latency", first_valid, 0);
    chk("done_after_last_valid", done_cyc, last_valid + 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

`ifdef TILE_CFG_SEQ_VALID_CHECK_EN
  task automatic start_refused();
    run_start_i = 1'b1;
    run_iters_i = 16'd1;
    tick();
    run_start_i = 1'b0;
    @(negedge clk_i);
    chk("refuse_err", err_o, 1);
    chk("refuse_busy", busy_o, 0);
    chk("refuse_valid", cfg_valid_o, 0);
    tick();
    @(negedge clk_i);
    chk("refuse_err_one_cycle", err_o, 0);
    chk("refuse_ready", cfg_ready_o, 1);
    tick();
  endtask
`endif

  initial begin
    vecs[0] = '{d: {W'(64'h44), W'(64'h33), W'(64'h22), W'(64'h11)}, iters: 2, stall_idx: -1, stall_len: 0, exp_valid: 8};
    vecs[1] = '{d: {W'(64'h44), W'(64'h33), W'(64'h22), W'(64'h11)}, iters: 2, stall_idx: 2, stall_len: 3, exp_valid: 11};
    vecs[2] = '{d: {W'(64'hD4), W'(64'hC3), W'(64'hB2), W'(64'h1_0000_0000_00A1)}, iters: 3, stall_idx: 0, stall_len: 1, exp_valid: 13};
    vecs[3] = '{d: {W'(64'h04), W'(64'h03), W'(64'h02), W'(64'h01)}, iters: 1, stall_idx: 3, stall_len: 2, exp_valid: 6};

    rst_i = 1'b1; cfg_addr_i = '0; cfg_data_i = '0; cfg_wr_en_i = 1'b0; cfg_wr_valid_i = 1'b0;
    run_start_i = 1'b0; run_iters_i = 16'd0; tile_stall_i = 1'b0;
    for (int i = 0; i < K; i++) model[i] = '0;
    tick(); tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", cfg_ready_o, 1);
    chk("rst_valid", cfg_valid_o, 0);
    chk("rst_cfg", cfg_o, 0);
    chk("rst_idx", cfg_idx_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    tick();

    run_start_i = 1'b1; run_iters_i = 16'd0;
    tick();
    run_start_i = 1'b0;
    @(negedge clk_i);
    chk("zero_iters_busy", busy_o, 0);
    chk("zero_iters_ready", cfg_ready_o, 1);
    chk("zero_iters_err", err_o, 0);
    chk("zero_iters_valid", cfg_valid_o, 0);
    tick();

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < K; i++) write_entry(i, vecs[v].d[i]);
      run(vecs[v].iters, vecs[v].stall_idx, vecs[v].stall_len, 0, '0, 0, vc);
      chk("valid_cycles", vc, vecs[v].exp_valid);
    end

    for (int i = 0; i < K; i++) write_entry(i, W'(64'h11 * (i + 1)));
    run(1, -1, 0, 0, '0, 1, vc);
    run(1, -1, 0, 0, '0, 0, vc);
    chk("write_in_run_dropped_cycles", vc, 4);

    run(1, -1, 0, 1, W'(64'hAB), 0, vc);
    chk("same_cycle_write_cycles", vc, 4);

    run_start_i = 1'b1; run_iters_i = 16'd1;
    tick();
    run_start_i = 1'b0;
    for (int n = 0; n < 20 && cfg_idx_o != AW'(2); n++) tick();
    chk("reached_idx2", cfg_idx_o, 2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_valid", cfg_valid_o, 0);
    chk("midrst_cfg", cfg_o, 0);
    chk("midrst_ready", cfg_ready_o, 1);
    chk("midrst_done", done_o, 0);
    chk("midrst_busy", busy_o, 0);
    tick();
    for (int i = 0; i < K; i++) model[i] = '0;
    exp_q.delete();

`ifdef TILE_CFG_SEQ_VALID_CHECK_EN
    start_refused();
    for (int i = 0; i < 3; i++) write_entry(i, W'(64'h5 + i));
    start_refused();
    write_entry(3, W'(64'h8));
    run(1, -1, 0, 0, '0, 0, vc);
    chk("mask_full_run_cycles", vc, 4);
`else
    run(1, -1, 0, 0, '0, 0, vc);
    chk("readback_zero_cycles", vc, 4);
    for (int i = 0; i < 3; i++) write_entry(i, W'(64'h5 + i));
    run(1, -1, 0, 0, '0, 0, vc);
    chk("partial_write_cycles", vc, 4);
    @(negedge clk_i);
    chk("err_tied_low", err_o, 0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
